// File: rtl/dmux4way_pkg.sv
// ============================================================================
// dmux4way_pkg : shared constants and helpers for the 1-to-4 stream demux
// Revision     : 1.0
// ============================================================================
`default_nettype none

package dmux4way_pkg;

   localparam int NUM_CH  = 4;
   localparam int SEL_W   = 2;
   localparam int COUNT_W = 8;

   localparam logic [SEL_W-1:0] CH0 = 2'd0;
   localparam logic [SEL_W-1:0] CH1 = 2'd1;
   localparam logic [SEL_W-1:0] CH2 = 2'd2;
   localparam logic [SEL_W-1:0] CH3 = 2'd3;

   typedef logic [SEL_W-1:0] ch_sel_t;

   function automatic logic [NUM_CH-1:0] sel_onehot(input ch_sel_t sel);
      logic [NUM_CH-1:0] oh;
      oh = '0;
      oh[sel] = 1'b1;
      return oh;
   endfunction

endpackage : dmux4way_pkg

`default_nettype wire

// File: rtl/dmux4way_slot.sv
// ============================================================================
// dmux4way_slot : one-entry holding register for a single demux channel;
//                 pop counter present only with DMUX4WAY_STATS_EN
// Revision      : 1.0
// ============================================================================
`default_nettype none

module dmux4way_slot
   import dmux4way_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_ready,
   output logic             full,
   output logic [WIDTH-1:0] data
`ifdef DMUX4WAY_STATS_EN
   ,
   output logic [COUNT_W-1:0] count
`endif
);

   logic pop;

   assign pop = full && pop_ready;

   // A push wins over a pop so that a simultaneous push+pop refills the slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         data <= '0;
      end else if (push) begin
         full <= 1'b1;
         data <= push_data;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

`ifdef DMUX4WAY_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (pop) begin
         count <= count + COUNT_W'(1);
      end
   end
`endif

endmodule : dmux4way_slot

`default_nettype wire

// File: rtl/dmux4way_stream.sv
// ============================================================================
// dmux4way_stream : registered 1-to-4 stream demultiplexer (select decode,
//                   acceptance mux, port packing); stats via DMUX4WAY_STATS_EN
// Revision        : 1.0
// ============================================================================
`default_nettype none

module dmux4way_stream
   import dmux4way_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   input  logic [SEL_W-1:0]        in_sel,
   output logic [NUM_CH-1:0]       out_valid,
   input  logic [NUM_CH-1:0]       out_ready,
   output logic [NUM_CH*WIDTH-1:0] out_data
`ifdef DMUX4WAY_STATS_EN
   ,
   output logic [NUM_CH*COUNT_W-1:0] out_count
`endif
);

   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] sel_oh;

   // Acceptance depends only on the addressed slot, never on in_valid.
   assign in_ready  = !full[in_sel] || out_ready[in_sel];
   assign sel_oh    = sel_onehot(in_sel);
   assign push      = (in_valid && in_ready) ? sel_oh : '0;
   assign out_valid = full;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      dmux4way_slot #(
         .WIDTH     (WIDTH)
      ) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .push      (push[k]),
         .push_data (in_data),
         .pop_ready (out_ready[k]),
         .full      (full[k]),
         .data      (out_data[k*WIDTH +: WIDTH])
`ifdef DMUX4WAY_STATS_EN
         ,
         .count     (out_count[k*COUNT_W +: COUNT_W])
`endif
      );
   end

endmodule : dmux4way_stream

`default_nettype wire

// File: tb/tb_dmux4way_stream.sv
// ============================================================================
// tb_dmux4way_stream : directed vector bench for dmux4way_stream
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_dmux4way_stream;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [1:0]  in_sel;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [63:0] out_data;
`ifdef DMUX4WAY_STATS_EN
   logic [31:0] out_count;
`endif

   int checks = 0;
   int errors = 0;

   dmux4way_stream #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef DMUX4WAY_STATS_EN
      ,
      .out_count (out_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [1:0]  sel;
      logic [15:0] d;
      logic [3:0]  rdy;
      logic        exp_rdy;
      logic [3:0]  exp_vld;
      logic [63:0] exp_data;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive at the falling edge, check readiness, then check slots after the rising edge.
   task automatic apply(input vec_t t, input string tag);
      @(negedge clk);
      in_valid  = t.v;
      in_sel    = t.sel;
      in_data   = t.d;
      out_ready = t.rdy;
      #1;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'(t.exp_rdy));
      @(posedge clk);
      #1;
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(t.exp_vld));
      chk({tag, "_out_data"}, out_data, t.exp_data);
   endtask

   initial begin
      // routing
      vecs[0]  = '{1'b1, 2'd0, 16'hA001, 4'b1111, 1'b1, 4'b0001, 64'h0000_0000_0000_A001};
      vecs[1]  = '{1'b1, 2'd1, 16'hB002, 4'b1111, 1'b1, 4'b0010, 64'h0000_0000_B002_A001};
      vecs[2]  = '{1'b1, 2'd2, 16'hC003, 4'b1111, 1'b1, 4'b0100, 64'h0000_C003_B002_A001};
      vecs[3]  = '{1'b1, 2'd3, 16'hD004, 4'b1111, 1'b1, 4'b1000, 64'hD004_C003_B002_A001};
      vecs[4]  = '{1'b0, 2'd0, 16'hFFFF, 4'b1111, 1'b1, 4'b0000, 64'hD004_C003_B002_A001};
      // back-pressure on channel 2
      vecs[5]  = '{1'b1, 2'd2, 16'h1111, 4'b1011, 1'b1, 4'b0100, 64'hD004_1111_B002_A001};
      vecs[6]  = '{1'b1, 2'd2, 16'h2222, 4'b1011, 1'b0, 4'b0100, 64'hD004_1111_B002_A001};
      vecs[7]  = '{1'b1, 2'd0, 16'h3333, 4'b1011, 1'b1, 4'b0101, 64'hD004_1111_B002_3333};
      vecs[8]  = '{1'b1, 2'd2, 16'h2222, 4'b1111, 1'b1, 4'b0100, 64'hD004_2222_B002_3333};
      vecs[9]  = '{1'b0, 2'd2, 16'h0000, 4'b1111, 1'b1, 4'b0000, 64'hD004_2222_B002_3333};
      // same-cycle push and pop on channel 1
      vecs[10] = '{1'b1, 2'd1, 16'h0055, 4'b0000, 1'b1, 4'b0010, 64'hD004_2222_0055_3333};
      vecs[11] = '{1'b1, 2'd1, 16'h00AA, 4'b0010, 1'b1, 4'b0010, 64'hD004_2222_00AA_3333};
      // stalled producer changes select
      vecs[12] = '{1'b1, 2'd0, 16'h7777, 4'b0000, 1'b1, 4'b0011, 64'hD004_2222_00AA_7777};
      vecs[13] = '{1'b1, 2'd0, 16'h8888, 4'b0000, 1'b0, 4'b0011, 64'hD004_2222_00AA_7777};
      vecs[14] = '{1'b1, 2'd3, 16'h8888, 4'b0000, 1'b1, 4'b1011, 64'h8888_2222_00AA_7777};
      vecs[15] = '{1'b0, 2'd0, 16'h0000, 4'b0001, 1'b1, 4'b1010, 64'h8888_2222_00AA_7777};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 2'd0;
      in_data   = 16'h0;
      out_ready = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'h0);
      chk("reset_out_data", out_data, 64'h0);
      chk("reset_in_ready", 64'(in_ready), 64'h1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) apply(vecs[i], $sformatf("v%0d", i));

      // asynchronous reset mid-stream with slots 1 and 3 full
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", 64'(out_valid), 64'h0);
      chk("midreset_out_data", out_data, 64'h0);
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         chk($sformatf("midreset_in_ready_sel%0d", s), 64'(in_ready), 64'h1);
      end
      in_valid = 1'b1;
      in_sel   = 2'd1;
      in_data  = 16'h5A5A;
      @(posedge clk);
      #1;
      chk("reset_edge_no_push", 64'(out_valid), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      in_data = 16'h1234;
      @(posedge clk);
      #1;
      chk("first_edge_out_valid", 64'(out_valid), 64'h2);
      chk("first_edge_out_data", out_data, 64'h0000_0000_1234_0000);

`ifdef DMUX4WAY_STATS_EN
      // one pop just happened nowhere yet; drain channel 1 then reset counters
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("stats_reset", 64'(out_count), 64'h0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 4'b1111;
      in_valid  = 1'b1;
      in_sel    = 2'd0;
      for (int i = 0; i < 257; i++) begin
         in_data = 16'(i);
         @(negedge clk);
      end
      in_sel = 2'd2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("stats_ch0", 64'(out_count[7:0]), 64'd1);
      chk("stats_ch1", 64'(out_count[15:8]), 64'd0);
      chk("stats_ch2", 64'(out_count[23:16]), 64'd3);
      chk("stats_ch3", 64'(out_count[31:24]), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_dmux4way_stream

`default_nettype wire

// File: doc/dmux4way_stream.md
# dmux4way_stream

- Registered 1-to-4 stream demultiplexer: the distribution-side counterpart of the 4-way mux.
- Each accepted input word is steered by a 2-bit select into one of four output channels.
- Each output channel has a one-entry holding register with its own valid/ready handshake.
- Sits between a single producer (e.g. CPU output path) and four independent consumers; back-pressure on one channel does not block traffic to the others.

## Interface
- WIDTH, 16, data word width in bits
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  word to route
- in_sel  input  2  destination channel: 00→0, 01→1, 10→2, 11→3
- out_valid  output  4  bit k: channel k holds a word
- out_ready  input  4  bit k: consumer k takes the word
- out_data  output  4*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
- out_count  output  32  per-channel transfer counters, 8 bits each, channel k at [k*8 +: 8]; present only with DMUX4WAY_STATS_EN

## Operation
- Each channel k has a slot: full_k flag plus data_k register.
- out_valid[k] = full_k; out_data slice k = data_k.
- Input acceptance: in_ready = !full[in_sel] || out_ready[in_sel].
  - in_ready is combinational from in_sel, full and out_ready; it does not depend on in_valid.
- Push: in_valid && in_ready writes in_data into slot in_sel and sets full.
- Pop: out_valid[k] && out_ready[k] clears full_k, unless slot k is pushed in the same cycle.
- Simultaneous push and pop on the same channel: full stays 1 and data is replaced by the new word. No bubble; this gives full throughput of one word per cycle per channel.
- Pops on other channels proceed independently in the same cycle as a push.
- Only the selected slot changes on a push. Unselected slots keep their data and flags; in_data never leaks into them.
- Word ordering within a channel is preserved. Words on different channels have no ordering relation.
- in_sel and in_data may change freely while in_valid = 0.
- A stalled producer (in_valid = 1, in_ready = 0) may change in_sel. The block routes whatever is presented at the accepting edge.

## Timing
- Latency: a word accepted at edge N is visible on out_valid/out_data immediately after edge N, so a consumer can take it at edge N+1.
- Reset (rst_n low, asynchronous):
  - full_k = 0, so out_valid = 4'b0000.
  - data_k = 0, so out_data = 0.
  - out_count = 0.
  - in_ready then equals 1 for any in_sel.
- Reset mid-operation discards all held words; no transfer completes on an edge while rst_n is low.
- Release of rst_n is synchronous to clk by the surrounding system. The block starts accepting on the first edge with rst_n high.
- Throughput: one word per cycle aggregate. This is sustained indefinitely when the destination consumer is ready, or the destination slot is empty.

## Configuration
- DMUX4WAY_STATS_EN defined:
  - Four 8-bit counters; counter k increments on each pop of channel k (out_valid[k] && out_ready[k]).
  - 255 wraps to 0.
  - Counters reset to 0 on rst_n.
  - Several channels popping in one cycle each increment their own counter.
- DMUX4WAY_STATS_EN undefined: out_count port and counters are absent. All routing behaviour is identical.

## Structure
- Package dmux4way_pkg holds:
  - NUM_CH = 4
  - SEL_W = 2
  - COUNT_W = 8
  - channel index constants CH0..CH3
- Sub-module dmux4way_slot: one-entry register slice (full flag, data register, push/pop logic, optional counter), instantiated NUM_CH times.
- Top-level dmux4way_stream contains only select decode, in_ready mux and port packing.

## Test plan
- Reset: assert rst_n = 0 mid-stream with slots 1 and 3 full → out_valid = 0000, out_data = 0, in_ready = 1 for every in_sel.
- Routing: out_ready = 1111, push 16'hA001/00, 16'hB002/01, 16'hC003/10, 16'hD004/11 on consecutive cycles → each word appears one cycle later on only its channel; other slots unchanged.
- Back-pressure: out_ready[2] = 0, push 16'h1111 then 16'h2222 to sel 10 → second word stalls (in_ready = 0). Meanwhile push 16'h3333 to sel 00 → accepted in the same cycle. Release out_ready[2] → 16'h1111 then 16'h2222 delivered in order.
- Same-cycle push+pop: slot 1 holds 16'h0055 with out_ready[1] = 1 and a push of 16'h00AA to sel 01 → in_ready = 1, out_valid[1] stays 1, next value 16'h00AA, no idle cycle.
- Stalled select change: slot 0 full with out_ready[0] = 0, present in_sel = 00 (in_ready = 0), then switch to in_sel = 11 → word accepted into channel 3.
- Stats (DMUX4WAY_STATS_EN): 257 pops on channel 0 and 3 on channel 2 → out_count[7:0] = 1, out_count[23:16] = 3, others 0.
